// File: rtl/hv_cfg_pkg.sv
// Shared types and helpers for the HV supply configuration exchange.
package hv_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_REP = 3'd2,
    RECV     = 3'd3,
    DONE     = 3'd4
  } state_e;

  // 100 ms of RX silence at 40 MHz
  localparam int HV_TIMEOUT_DEFAULT = 4000000;

  localparam int CSUM_MAX_BYTES = 32;

  // True when the XOR of bytes 0..nbytes-2 equals byte nbytes-1.
  function automatic logic csum_ok(input logic [8*CSUM_MAX_BYTES-1:0] data,
                                   input int nbytes);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < CSUM_MAX_BYTES - 1; i++)
      if (i < nbytes - 1) acc ^= data[8*i +: 8];
    return acc == data[8*(nbytes-1) +: 8];
  endfunction

endpackage

// File: rtl/hv_config_ctrl_if.sv
// Command/reply bundle between the master FSM, the UART and hv_config_ctrl.
interface hv_config_ctrl_if #(
  parameter int CMD_BYTES = 8,
  parameter int REP_BYTES = 8
);
  logic                   hv_wr;
  logic [8*CMD_BYTES-1:0] cfg_data;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   hv_config_rep_receive;
  logic                   hv_config_done;
  logic [8*REP_BYTES-1:0] rep_data;
  logic                   rep_ok;
  logic                   timeout_err;

  modport slave (
    input  hv_wr, cfg_data, tx_ready, rx_data, rx_valid,
    output tx_data, tx_valid, hv_config_rep_receive, hv_config_done,
           rep_data, rep_ok, timeout_err
  );

  modport master (
    output hv_wr, cfg_data, tx_ready, rx_data, rx_valid,
    input  tx_data, tx_valid, hv_config_rep_receive, hv_config_done,
           rep_data, rep_ok, timeout_err
  );
endinterface

// File: rtl/hv_config_ctrl.sv
// Sends a latched command to the HV module, collects its reply and releases
// the master FSM with rep_receive/done pulses; RX silence always ends the exchange.
module hv_config_ctrl import hv_cfg_pkg::*; #(
  parameter int CMD_BYTES      = 8,
  parameter int REP_BYTES      = 8,
  parameter int TIMEOUT_CYCLES = HV_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  hv_config_ctrl_if.slave bus
);

  localparam int MAXB = (CMD_BYTES > REP_BYTES) ? CMD_BYTES : REP_BYTES;
  localparam int IW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  state_e                 state_q;
  logic [8*CMD_BYTES-1:0] cmd_q;
  logic [8*REP_BYTES-1:0] rep_q, rep_d;
  logic [IW-1:0]          idx_q, idx_inc;
  logic [TW-1:0]          tout_q;
  logic                   tout_hit;
  logic [7:0]             tx_data_q;
  logic                   tx_valid_q, rep_rcv_q, done_q, rep_ok_q, tout_err_q;

  assign idx_inc  = idx_q + 1'b1;
  // Fires on the cycle the silence count reaches TIMEOUT_CYCLES.
  assign tout_hit = (tout_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    rep_d = rep_q;
    rep_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      rep_q      <= '0;
      idx_q      <= '0;
      tout_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rep_rcv_q  <= 1'b0;
      done_q     <= 1'b0;
      rep_ok_q   <= 1'b0;
      tout_err_q <= 1'b0;
    end else begin
      rep_rcv_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.hv_wr) begin
          cmd_q      <= bus.cfg_data;
          rep_q      <= '0;
          rep_ok_q   <= 1'b0;
          tout_err_q <= 1'b0;
          idx_q      <= '0;
          tx_data_q  <= bus.cfg_data[7:0];
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: if (bus.tx_ready) begin
          if (idx_q == IW'(CMD_BYTES - 1)) begin
            tx_valid_q <= 1'b0;
            tout_q     <= '0;
            idx_q      <= '0;
            state_q    <= WAIT_REP;
          end else begin
            idx_q     <= idx_inc;
            tx_data_q <= cmd_q[{idx_inc, 3'b000} +: 8];
          end
        end
        WAIT_REP: begin
          if (bus.rx_valid) begin
            rep_q     <= rep_d;
            idx_q     <= idx_inc;
            tout_q    <= '0;
            rep_rcv_q <= 1'b1;
            state_q   <= RECV;
          end else if (tout_hit) begin
            rep_rcv_q  <= 1'b1;
            tout_err_q <= 1'b1;
            state_q    <= DONE;
          end else if (tout_q != TW'(TIMEOUT_CYCLES)) begin
            tout_q <= tout_q + 1'b1;
          end
        end
        RECV: begin
          if (bus.rx_valid) begin
            rep_q  <= rep_d;
            tout_q <= '0;
            if (idx_q == IW'(REP_BYTES - 1)) begin
              rep_ok_q <= csum_ok((8*CSUM_MAX_BYTES)'(rep_d), REP_BYTES);
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              idx_q <= idx_inc;
            end
          end else if (tout_hit) begin
            tout_err_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else if (tout_q != TW'(TIMEOUT_CYCLES)) begin
            tout_q <= tout_q + 1'b1;
          end
        end
        // Entered with done_q low only after a WAIT_REP timeout, so done
        // lands one cycle behind rep_receive.
        DONE: begin
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data               = tx_data_q;
  assign bus.tx_valid              = tx_valid_q;
  assign bus.hv_config_rep_receive = rep_rcv_q;
  assign bus.hv_config_done        = done_q;
  assign bus.rep_data              = rep_q;
  assign bus.rep_ok                = rep_ok_q;
  assign bus.timeout_err           = tout_err_q;

endmodule
